seg7_count_display: RTL and testbench

//  Downstream consumer of the 8-bit seconds counter: shows its value as decimal 000..255 on the
//  4-digit multiplexed 7-segment display. A sequential double-dabble converter turns binary into
//  BCD; a refresh scanner time-multiplexes the digits onto shared active-low segment/anode pins.

---
 rtl/seg7_count_display_pkg.sv | 40 ++++
 rtl/seg7_count_display_bin_to_bcd_seq.sv | 76 +++++++
 rtl/seg7_count_display.sv | 78 +++++++
 tb/tb_seg7_count_display.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/seg7_count_display_pkg.sv
// Shared definitions for the 7-segment count display: segment codes (active-low {g,f,e,d,c,b,a}),
// converter state encoding and the BCD-to-segment decode helper.
package seg7_count_display_pkg;

   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } conv_state_t;

   // Nibbles above 9 cannot come out of the converter; they decode as blank.
   function automatic logic [6:0] seg_decode(input logic [3:0] digit);
      case (digit)
         4'd0:    seg_decode = SEG_0;
         4'd1:    seg_decode = SEG_1;
         4'd2:    seg_decode = SEG_2;
         4'd3:    seg_decode = SEG_3;
         4'd4:    seg_decode = SEG_4;
         4'd5:    seg_decode = SEG_5;
         4'd6:    seg_decode = SEG_6;
         4'd7:    seg_decode = SEG_7;
         4'd8:    seg_decode = SEG_8;
         4'd9:    seg_decode = SEG_9;
         default: seg_decode = SEG_BLANK;
      endcase
   endfunction

endpackage

// File: rtl/seg7_count_display_bin_to_bcd_seq.sv
// Sequential double-dabble converter: 8-bit binary to three BCD digits in 10 clocks
// (load, 8 shift cycles, commit). The input is only sampled while idle.
module bin_to_bcd_seq
   import seg7_count_display_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] value,
   output logic [3:0] hund,
   output logic [3:0] tens,
   output logic [3:0] ones,
   output logic       valid
);

   conv_state_t state;
   logic [7:0]  sr;
   logic [7:0]  load_val;
   logic [7:0]  last_val;
   logic [11:0] bcd;
   logic [11:0] bcd_adj;
   logic [2:0]  bit_cnt;

   // NOTE: every signal driven in always_comb gets a default first, so no path can infer a latch.
   always_comb begin
      bcd_adj = bcd;
      for (int i = 0; i < 3; i++) begin
         if (bcd[i*4 +: 4] >= 4'd5)
            bcd_adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= ST_IDLE;
         sr       <= '0;
         load_val <= '0;
         last_val <= '0;
         bcd      <= '0;
         bit_cnt  <= '0;
         hund     <= '0;
         tens     <= '0;
         ones     <= '0;
         valid    <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (!valid || value != last_val) begin
                  sr       <= value;
                  load_val <= value;
                  bcd      <= '0;
                  bit_cnt  <= '0;
                  state    <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               bcd     <= {bcd_adj[10:0], sr[7]};
               sr      <= {sr[6:0], 1'b0};
               bit_cnt <= bit_cnt + 3'd1;
               if (bit_cnt == 3'd7)
                  state <= ST_DONE;
            end
            ST_DONE: begin
               hund     <= bcd[11:8];
               tens     <= bcd[7:4];
               ones     <= bcd[3:0];
               last_val <= load_val;
               valid    <= 1'b1;
               state    <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/seg7_count_display.sv
// Shows an 8-bit value as decimal 000..255 on a 4-digit multiplexed active-low 7-segment display.
// Build option: SEG7_LEADING_ZERO_BLANK_EN blanks leading zeros on the hundreds/tens digits.
module seg7_count_display
   import seg7_count_display_pkg::*;
#(
   parameter int REFRESH_DIV = 50000,
   parameter int PRESC_W     = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] value,
   output logic [6:0] seg,
   output logic       dp,
   output logic [3:0] an
);

   localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(REFRESH_DIV - 1);

   logic [3:0]         hund;
   logic [3:0]         tens;
   logic [3:0]         ones;
   logic               valid;
   logic [PRESC_W-1:0] presc;
   logic [1:0]         sel;
   logic               hund_blank;
   logic               tens_blank;
   logic [6:0]         shown;

   bin_to_bcd_seq u_conv (
      .clk   (clk),
      .reset (reset),
      .value (value),
      .hund  (hund),
      .tens  (tens),
      .ones  (ones),
      .valid (valid)
   );

`ifdef SEG7_LEADING_ZERO_BLANK_EN
   assign hund_blank = (hund == 4'd0);
   assign tens_blank = (hund == 4'd0) && (tens == 4'd0);
`else
   assign hund_blank = 1'b0;
   assign tens_blank = 1'b0;
`endif

   assign dp = 1'b1;

   always_comb begin
      shown = SEG_BLANK;
      case (sel)
         2'd0:    shown = seg_decode(ones);
         2'd1:    shown = tens_blank ? SEG_BLANK : seg_decode(tens);
         2'd2:    shown = hund_blank ? SEG_BLANK : seg_decode(hund);
         default: shown = SEG_BLANK;
      endcase
   end

   // Anode and segment registers follow sel every cycle, so both switch on the same edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         presc <= '0;
         sel   <= 2'd0;
         an    <= 4'b1111;
         seg   <= SEG_BLANK;
      end else begin
         if (presc == PRESC_MAX) begin
            presc <= '0;
            sel   <= sel + 2'd1;
         end else begin
            presc <= presc + 1'b1;
         end
         an  <= ~(4'b0001 << sel);
         seg <= shown;
      end
   end

endmodule

// File: tb/tb_seg7_count_display.sv
// Self-checking bench for seg7_count_display with REFRESH_DIV=4: table of display vectors
// plus hand-written sequences for conversion latency, mid-conversion changes and reset.
module tb_seg7_count_display;

   localparam logic [6:0] C0 = 7'b1000000;
   localparam logic [6:0] C1 = 7'b1111001;
   localparam logic [6:0] C2 = 7'b0100100;
   localparam logic [6:0] C4 = 7'b0011001;
   localparam logic [6:0] C5 = 7'b0010010;
   localparam logic [6:0] C7 = 7'b1111000;
   localparam logic [6:0] C9 = 7'b0010000;
   localparam logic [6:0] CB = 7'b1111111;

`ifdef SEG7_LEADING_ZERO_BLANK_EN
   localparam logic [6:0] LZ = CB;
`else
   localparam logic [6:0] LZ = C0;
`endif

   typedef struct {
      logic [7:0] value;
      logic [6:0] h;
      logic [6:0] t;
      logic [6:0] o;
   } vec_t;

   typedef struct {
      logic [3:0] an;
      logic [6:0] seg;
   } scan_t;

   logic       clk;
   logic       reset;
   logic [7:0] value;
   logic [6:0] seg;
   logic       dp;
   logic [3:0] an;

   int vectors = 0;
   int miscompares = 0;

   seg7_count_display #(.REFRESH_DIV(4), .PRESC_W(16)) dut (
      .clk   (clk),
      .reset (reset),
      .value (value),
      .seg   (seg),
      .dp    (dp),
      .an    (an)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] digits();
      return {4'h0, dut.hund, dut.tens, dut.ones};
   endfunction

   // Wait for the start of the ones slot, then compare one full scan (4 slots x 4 clocks) and the wrap.
   task automatic scan_check(input string name, input logic [6:0] eh, input logic [6:0] et,
                             input logic [6:0] eo);
      scan_t      exp_q[$];
      scan_t      e;
      logic [3:0] an_tab[4];
      logic [6:0] seg_tab[4];
      logic [3:0] prev;
      int         n;
      an_tab  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
      seg_tab = '{eo, et, eh, CB};
      for (int s = 0; s < 4; s++)
         for (int k = 0; k < 4; k++) begin
            e.an  = an_tab[s];
            e.seg = seg_tab[s];
            exp_q.push_back(e);
         end
      @(negedge clk);
      prev = an;
      n = 0;
      forever begin
         @(negedge clk);
         if (an == 4'b1110 && prev != 4'b1110) break;
         prev = an;
         n++;
         if (n > 40) begin
            check({name, "_sync_timeout"}, 16'd0, 16'd1);
            return;
         end
      end
      for (int i = 0; i < 16; i++) begin
         if (i > 0) @(negedge clk);
         e = exp_q.pop_front();
         check($sformatf("%s_an%0d", name, i), {12'h0, an}, {12'h0, e.an});
         check($sformatf("%s_seg%0d", name, i), {9'h0, seg}, {9'h0, e.seg});
      end
      check({name, "_dp"}, {15'h0, dp}, 16'd1);
      @(negedge clk);
      check({name, "_wrap"}, {12'h0, an}, 16'h000e);
   endtask

   task automatic apply(input logic [7:0] v);
      @(posedge clk);
      #1 value = v;
   endtask

   vec_t tab[8];

   initial begin
      tab[0] = '{8'd0,   LZ, LZ, C0};
      tab[1] = '{8'd255, C2, C5, C5};
      tab[2] = '{8'd7,   LZ, LZ, C7};
      tab[3] = '{8'd100, C1, C0, C0};
      tab[4] = '{8'd42,  LZ, C4, C2};
      tab[5] = '{8'd9,   LZ, LZ, C9};
      tab[6] = '{8'd10,  LZ, C1, C0};
      tab[7] = '{8'd199, C1, C9, C9};

      // Reset applies asynchronously, before any clock edge.
      value = 8'd0;
      reset = 1'b0;
      #1 reset = 1'b1;
      #2;
      check("rst_seg", {9'h0, seg}, {9'h0, CB});
      check("rst_an", {12'h0, an}, 16'h000f);
      check("rst_dp", {15'h0, dp}, 16'd1);
      check("rst_valid", {15'h0, dut.valid}, 16'd0);
      repeat (2) @(negedge clk);
      reset = 1'b0;

      // First conversion after reset: valid rises on the 10th edge.
      repeat (9) @(posedge clk);
      @(negedge clk);
      check("init_valid_edge9", {15'h0, dut.valid}, 16'd0);
      @(posedge clk);
      @(negedge clk);
      check("init_valid_edge10", {15'h0, dut.valid}, 16'd1);
      check("init_digits", digits(), 16'h0000);

      for (int i = 0; i < 8; i++) begin
         apply(tab[i].value);
         repeat (12) @(posedge clk);
         check($sformatf("tab%0d_digits_valid", i), {15'h0, dut.valid}, 16'd1);
         scan_check($sformatf("tab%0d", i), tab[i].h, tab[i].t, tab[i].o);
      end

      // Mid-conversion change: 42 completes, then 43 is picked up on return to idle.
      apply(8'd255);
      repeat (14) @(posedge clk);
      apply(8'd42);
      repeat (3) @(posedge clk);
      #1 value = 8'd43;
      repeat (6) @(posedge clk);
      @(negedge clk);
      check("chg_edge9", digits(), 16'h0255);
      @(posedge clk);
      @(negedge clk);
      check("chg_edge10", digits(), 16'h0042);
      repeat (9) @(posedge clk);
      @(negedge clk);
      check("chg_edge19", digits(), 16'h0042);
      @(posedge clk);
      @(negedge clk);
      check("chg_edge20", digits(), 16'h0043);
      scan_check("chg43", LZ, C4, 7'b0110000);

      // Reset pulsed mid-shift with 200 held: outputs clear at once, 200 reappears 10 clocks later.
      apply(8'd200);
      repeat (4) @(posedge clk);
      #2 reset = 1'b1;
      #1;
      check("midrst_seg", {9'h0, seg}, {9'h0, CB});
      check("midrst_an", {12'h0, an}, 16'h000f);
      check("midrst_dp", {15'h0, dp}, 16'd1);
      check("midrst_digits", digits(), 16'h0000);
      check("midrst_valid", {15'h0, dut.valid}, 16'd0);
      @(negedge clk);
      reset = 1'b0;
      repeat (9) @(posedge clk);
      @(negedge clk);
      check("midrst_edge9", digits(), 16'h0000);
      @(posedge clk);
      @(negedge clk);
      check("midrst_edge10", digits(), 16'h0200);
      check("midrst_valid10", {15'h0, dut.valid}, 16'd1);
      scan_check("rst200", C2, C0, C0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
